dual_slot_rr_arbiter: RTL

- Shares two identical resource slots (A, B) among 12 requesters.
- Each cycle, every idle slot receives the next eligible requester in round-robin order. Both slots can be granted in the same cycle, to distinct requesters.
- A grant is held until the slot signals completion or the requester withdraws.
- Sits between the requesting engines and the shared datapath pair. Grant IDs use the team's 1-based priority-encoder encoding: 0 = none, k = request bit k-1.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/rr_dual_pick.sv | 55 +++++
 rtl/dual_slot_rr_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared constants, slot state encoding and grant-ID helpers for dual_slot_rr_arbiter.
// Grant IDs are 1-based: 0 means no grant, k means request bit k-1.
package arb_pkg;

    localparam int N_REQ_DEF = 12;
    localparam int ID_W_DEF  = 4;
    localparam logic [ID_W_DEF-1:0] ID_NONE = 4'd0;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_BUSY = 1'b1
    } slot_state_e;

    function automatic logic [ID_W_DEF-1:0] idx_to_id(input logic [ID_W_DEF-1:0] idx);
        return idx + ID_W_DEF'(1);
    endfunction

    function automatic logic [N_REQ_DEF-1:0] id_to_onehot(input logic [ID_W_DEF-1:0] id);
        logic [N_REQ_DEF-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REQ_DEF; i++) begin
            if (id == idx_to_id(ID_W_DEF'(i))) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_dual_pick.sv
// Combinational round-robin search: finds the first two set bits of the eligible
// vector starting at ptr and wrapping, and reports their absolute indices.
module rr_dual_pick #(
    parameter int N_REQ = 12,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    first_idx,
    output logic             first_vld,
    output logic [IW-1:0]    second_idx,
    output logic             second_vld
);

    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    rot_first;
    logic [IW-1:0]    rot_second;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    // rot[0] is requester ptr, so a plain lowest-first scan gives round-robin order.
    always_comb begin
        rot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rot[j] = eligible[wrap_add(ptr, j)];
        end
    end

    always_comb begin
        first_vld  = 1'b0;
        second_vld = 1'b0;
        rot_first  = '0;
        rot_second = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (rot[j]) begin
                if (!first_vld) begin
                    first_vld = 1'b1;
                    rot_first = IW'(j);
                end else if (!second_vld) begin
                    second_vld = 1'b1;
                    rot_second = IW'(j);
                end
            end
        end
    end

    assign first_idx  = wrap_add(ptr, int'(rot_first));
    assign second_idx = wrap_add(ptr, int'(rot_second));

endmodule

// File: rtl/dual_slot_rr_arbiter.sv
// Two-slot round-robin arbiter: each idle slot takes the next eligible requester.
// Define ARB_TIMEOUT_EN to build per-slot hold counters that force release after MAX_HOLD.
module dual_slot_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done_a,
    input  logic             done_b,
    output logic [ID_W-1:0]  id_a,
    output logic [ID_W-1:0]  id_b,
    output logic [N_REQ-1:0] gnt,
    output logic             expired_a,
    output logic             expired_b
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 15 || ID_W != ID_W_DEF || MAX_HOLD < 1) begin : g_bad_cfg
        $error("dual_slot_rr_arbiter: unsupported parameter set");
    end

    slot_state_e      st_a_q, st_a_d, st_b_q, st_b_d;
    logic [ID_W-1:0]  id_a_q, id_a_d, id_b_q, id_b_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             exp_a_q, exp_a_d, exp_b_q, exp_b_d;

    logic [N_REQ-1:0] held_a, held_b, eligible;
    logic [IW-1:0]    first_idx, second_idx, win_b_idx;
    logic             first_vld, second_vld;
    logic             idle_a, idle_b, win_a, win_b;
    logic             quit_a, quit_b, rel_a, rel_b, to_a, to_b;

    function automatic logic [N_REQ-1:0] decode(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (id == ID_W'(idx_to_id(ID_W_DEF'(i))));
        end
        return oh;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
        return (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
    endfunction

    assign held_a   = decode(id_a_q);
    assign held_b   = decode(id_b_q);
    assign eligible = req & ~(held_a | held_b);

    rr_dual_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .eligible   (eligible),
        .ptr        (ptr_q),
        .first_idx  (first_idx),
        .first_vld  (first_vld),
        .second_idx (second_idx),
        .second_vld (second_vld)
    );

    // Only slots idle at the sampling edge compete, so a release never regrants on the same edge.
    assign idle_a    = (st_a_q == SLOT_IDLE);
    assign idle_b    = (st_b_q == SLOT_IDLE);
    assign win_a     = idle_a && first_vld;
    assign win_b     = idle_b && (idle_a ? second_vld : first_vld);
    assign win_b_idx = idle_a ? second_idx : first_idx;

    assign quit_a = !idle_a && (done_a || ~|(req & held_a));
    assign quit_b = !idle_b && (done_b || ~|(req & held_b));
    assign rel_a  = quit_a || to_a;
    assign rel_b  = quit_b || to_b;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD) + 1;

    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    // The edge on which the count would reach MAX_HOLD is the forced release edge.
    assign to_a = !idle_a && (cnt_a_q == CNT_W'(MAX_HOLD - 1));
    assign to_b = !idle_b && (cnt_b_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        cnt_a_d = (idle_a || rel_a) ? '0 : cnt_a_q + CNT_W'(1);
        cnt_b_d = (idle_b || rel_b) ? '0 : cnt_b_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end
`else
    assign to_a = 1'b0;
    assign to_b = 1'b0;
`endif

    always_comb begin
        st_a_d  = st_a_q;
        st_b_d  = st_b_q;
        id_a_d  = id_a_q;
        id_b_d  = id_b_q;
        ptr_d   = ptr_q;
        exp_a_d = to_a && !quit_a;
        exp_b_d = to_b && !quit_b;

        if (rel_a) begin
            st_a_d = SLOT_IDLE;
            id_a_d = ID_W'(ID_NONE);
        end else if (win_a) begin
            st_a_d = SLOT_BUSY;
            id_a_d = ID_W'(idx_to_id(ID_W_DEF'(first_idx)));
        end

        if (rel_b) begin
            st_b_d = SLOT_IDLE;
            id_b_d = ID_W'(ID_NONE);
        end else if (win_b) begin
            st_b_d = SLOT_BUSY;
            id_b_d = ID_W'(idx_to_id(ID_W_DEF'(win_b_idx)));
        end

        // Slot B's winner, when present, is always the later one in search order.
        if (win_b) begin
            ptr_d = next_ptr(win_b_idx);
        end else if (win_a) begin
            ptr_d = next_ptr(first_idx);
        end

        gnt_d = decode(id_a_d) | decode(id_b_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_a_q  <= SLOT_IDLE;
            st_b_q  <= SLOT_IDLE;
            id_a_q  <= ID_W'(ID_NONE);
            id_b_q  <= ID_W'(ID_NONE);
            gnt_q   <= '0;
            ptr_q   <= '0;
            exp_a_q <= 1'b0;
            exp_b_q <= 1'b0;
        end else begin
            st_a_q  <= st_a_d;
            st_b_q  <= st_b_d;
            id_a_q  <= id_a_d;
            id_b_q  <= id_b_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            exp_a_q <= exp_a_d;
            exp_b_q <= exp_b_d;
        end
    end

    assign id_a      = id_a_q;
    assign id_b      = id_b_q;
    assign gnt       = gnt_q;
    assign expired_a = exp_a_q;
    assign expired_b = exp_b_q;

endmodule
